// File: rtl/sensor_hub_pkg.sv
// sensor_hub_pkg: shared types and constants for sensor_hub.
//   state_e       dispatch FSM states
//   RSP_*         response codes generated by the hub itself
//   FRAME_BYTES   bytes per RX frame (3 when SENSOR_HUB_CHECKSUM_EN is defined)
//   fifo_entry_t  request FIFO entry {addr, cmd, err}
package sensor_hub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_SEND
  } state_e;

  localparam logic [7:0] RSP_BAD_ADDR = 8'hE0;
  localparam logic [7:0] RSP_TIMEOUT  = 8'hE1;
  localparam logic [7:0] RSP_BAD_CSUM = 8'hE2;

`ifdef SENSOR_HUB_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = 3;
`else
  localparam int unsigned FRAME_BYTES = 2;
`endif

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] cmd;
    logic       err;
  } fifo_entry_t;

  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/sensor_hub_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
//   clock, reset        clock and synchronous active-high reset
//   push, push_data     write request and data
//   pop, pop_data       read request; pop_data shows the head entry
//   full, empty         occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    pop_data = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sensor_hub.sv
// sensor_hub: request/response engine between UART byte streams and N sensors.
// Assembles RX frames {address, command}, queues them, dispatches one at a
// time with a one-hot select, waits with a timeout and serialises
// code + DATA_W/8 data bytes (MSB first) to UART TX.
// Optional feature: SENSOR_HUB_CHECKSUM_EN adds a third frame byte
// (address XOR command); a mismatch queues a 0xE2 error response instead.
//   clock, reset                      clock, synchronous active-high reset
//   rx_valid, rx_data                 received byte stream
//   sensor_sel, sensor_req_valid,
//   sensor_request                    request side to the sensors
//   sensor_rsp_valid, sensor_rsp_code,
//   sensor_rsp_data                   response from the selected sensor
//   tx_valid, tx_data, tx_busy,
//   tx_done                           UART TX handshake
//   fifo_overflow                     sticky frame-dropped flag
module sensor_hub
  import sensor_hub_pkg::*;
#(
  parameter int unsigned NUM_SENSORS    = 32,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic [NUM_SENSORS-1:0] sensor_sel,
  output logic                   sensor_req_valid,
  output logic [7:0]             sensor_request,
  input  logic                   sensor_rsp_valid,
  input  logic [7:0]             sensor_rsp_code,
  input  logic [DATA_W-1:0]      sensor_rsp_data,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic                   fifo_overflow
);

  localparam int unsigned DATA_BYTES = DATA_W / 8;
  localparam int unsigned PAY_W      = DATA_W + 8;
  localparam int unsigned TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IDX_W      = $clog2(FRAME_BYTES);

  // Frame assembler
  logic [IDX_W-1:0] asm_idx_q, asm_idx_d;
  logic [7:0]       asm_addr_q, asm_addr_d;
`ifdef SENSOR_HUB_CHECKSUM_EN
  logic [7:0]       asm_cmd_q, asm_cmd_d;
`endif
  logic             fifo_push;
  fifo_entry_t      push_entry;

  // Request FIFO
  logic             fifo_pop, fifo_full, fifo_empty;
  fifo_entry_t      fifo_head;

  // Dispatch / serialiser
  state_e           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [PAY_W-1:0] payload_q, payload_d;
  logic [2:0]       left_q, left_d;
  logic             tx_wait_q, tx_wait_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             overflow_q, overflow_d;

  always_comb begin
    asm_idx_d  = asm_idx_q;
    asm_addr_d = asm_addr_q;
`ifdef SENSOR_HUB_CHECKSUM_EN
    asm_cmd_d  = asm_cmd_q;
`endif
    fifo_push  = 1'b0;
    push_entry = '0;
    if (rx_valid) begin
      if (asm_idx_q == IDX_W'(FRAME_BYTES - 1)) begin
        asm_idx_d       = '0;
        fifo_push       = 1'b1;
        push_entry.addr = asm_addr_q;
`ifdef SENSOR_HUB_CHECKSUM_EN
        push_entry.cmd  = asm_cmd_q;
        push_entry.err  = (rx_data != (asm_addr_q ^ asm_cmd_q));
`else
        push_entry.cmd  = rx_data;
        push_entry.err  = 1'b0;
`endif
      end else begin
        asm_idx_d = asm_idx_q + IDX_W'(1);
        if (asm_idx_q == '0) asm_addr_d = rx_data;
`ifdef SENSOR_HUB_CHECKSUM_EN
        else asm_cmd_d = rx_data;
`endif
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A pop only happens when the FIFO is non-empty, so a same-cycle pop
  // always makes room for the push.
  assign overflow_d    = overflow_q | (fifo_push & fifo_full & ~fifo_pop);
  assign fifo_overflow = overflow_q;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    cmd_d            = cmd_q;
    payload_d        = payload_q;
    left_d           = left_q;
    tx_wait_d        = tx_wait_q;
    tmo_d            = '0;
    fifo_pop         = 1'b0;
    sensor_req_valid = 1'b0;
    tx_valid         = 1'b0;
    tx_data          = '0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          addr_d    = fifo_head.addr;
          cmd_d     = fifo_head.cmd;
          left_d    = 3'(DATA_BYTES);
          tx_wait_d = 1'b0;
          if (fifo_head.err) begin
            payload_d = {RSP_BAD_CSUM, {DATA_W{1'b0}}};
            state_d   = ST_SEND;
          end else if (32'(fifo_head.addr) >= NUM_SENSORS) begin
            payload_d = {RSP_BAD_ADDR, {DATA_W{1'b0}}};
            state_d   = ST_SEND;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        sensor_req_valid = 1'b1;
        state_d          = ST_WAIT;
      end
      ST_WAIT: begin
        // Response is checked first so it wins over a same-cycle expiry.
        if (sensor_rsp_valid) begin
          payload_d = {sensor_rsp_code, sensor_rsp_data};
          state_d   = ST_SEND;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          payload_d = {RSP_TIMEOUT, {DATA_W{1'b0}}};
          state_d   = ST_SEND;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_SEND: begin
        if (!tx_wait_q) begin
          if (!tx_busy) begin
            tx_valid  = 1'b1;
            tx_data   = payload_q[PAY_W-1 -: 8];
            tx_wait_d = 1'b1;
          end
        end else if (tx_done) begin
          tx_wait_d = 1'b0;
          if (left_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            left_d    = left_q - 3'd1;
            payload_d = payload_q << 8;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sensor_sel     = '0;
    sensor_request = '0;
    if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
        sensor_sel[i] = (addr_q == 8'(i));
      end
      sensor_request = cmd_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      asm_idx_q  <= '0;
      asm_addr_q <= '0;
`ifdef SENSOR_HUB_CHECKSUM_EN
      asm_cmd_q  <= '0;
`endif
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cmd_q      <= '0;
      payload_q  <= '0;
      left_q     <= '0;
      tx_wait_q  <= 1'b0;
      tmo_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      asm_idx_q  <= asm_idx_d;
      asm_addr_q <= asm_addr_d;
`ifdef SENSOR_HUB_CHECKSUM_EN
      asm_cmd_q  <= asm_cmd_d;
`endif
      state_q    <= state_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      payload_q  <= payload_d;
      left_q     <= left_d;
      tx_wait_q  <= tx_wait_d;
      tmo_q      <= tmo_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_sensor_hub.sv
// tb_sensor_hub: directed bench for sensor_hub (NUM_SENSORS=32, DATA_W=16,
// FIFO_DEPTH=4, TIMEOUT_CYCLES=100). Checksum vectors run only when
// SENSOR_HUB_CHECKSUM_EN is defined.
module tb_sensor_hub;

  localparam int unsigned NS = 32;
  localparam int unsigned DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic [NS-1:0] sensor_sel;
  logic          sensor_req_valid;
  logic [7:0]    sensor_request;
  logic          sensor_rsp_valid = 1'b0;
  logic [7:0]    sensor_rsp_code = '0;
  logic [DW-1:0] sensor_rsp_data = '0;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_busy = 1'b0;
  logic          tx_done = 1'b0;
  logic          fifo_overflow;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  sensor_hub #(
    .NUM_SENSORS    (NS),
    .DATA_W         (DW),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .sensor_sel       (sensor_sel),
    .sensor_req_valid (sensor_req_valid),
    .sensor_request   (sensor_request),
    .sensor_rsp_valid (sensor_rsp_valid),
    .sensor_rsp_code  (sensor_rsp_code),
    .sensor_rsp_data  (sensor_rsp_data),
    .tx_valid         (tx_valid),
    .tx_data          (tx_data),
    .tx_busy          (tx_busy),
    .tx_done          (tx_done),
    .fifo_overflow    (fifo_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_sel"}, sensor_sel, 32'h0);
    check({tag, "_req"}, {31'b0, sensor_req_valid}, 32'h0);
    check({tag, "_cmd"}, {24'b0, sensor_request}, 32'h0);
    check({tag, "_txv"}, {31'b0, tx_valid}, 32'h0);
    check({tag, "_ovf"}, {31'b0, fifo_overflow}, 32'h0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c);
    send_byte(a);
    send_byte(c);
`ifdef SENSOR_HUB_CHECKSUM_EN
    send_byte(a ^ c);
`endif
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (n < 300) begin
      @(negedge clock);
      n++;
      if (sensor_req_valid) break;
    end
    check("req_seen", {31'b0, sensor_req_valid}, 32'h1);
  endtask

  task automatic wait_tx(output int n);
    n = 0;
    #1;
    while (!tx_valid && n < 300) begin
      @(negedge clock);
      #1;
      n++;
    end
  endtask

  // Accepts one TX byte, then models the UART being busy for a few cycles.
  task automatic recv_byte(input logic [7:0] exp, input string tag, output int n);
    wait_tx(n);
    check({tag, "_valid"}, {31'b0, tx_valid}, 32'h1);
    check(tag, {24'b0, tx_data}, {24'b0, exp});
    @(posedge clock);
    #1 tx_busy = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check({tag, "_gap"}, {31'b0, tx_valid}, 32'h0);
    end
    @(negedge clock);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    @(posedge clock);
    #1 tx_done = 1'b0;
  endtask

  task automatic respond(input logic [7:0] code, input logic [DW-1:0] data);
    @(negedge clock);
    sensor_rsp_valid = 1'b1;
    sensor_rsp_code  = code;
    sensor_rsp_data  = data;
    @(negedge clock);
    sensor_rsp_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    logic [7:0] bad_addr [2];
    bad_addr[0] = 8'h40;
    bad_addr[1] = 8'h20;

    // Reset state
    repeat (3) @(negedge clock);
    check_quiet("rst");
    reset = 1'b0;

    // Basic transaction, TX gated by tx_busy
    send_frame(8'h03, 8'h21);
    wait_req(n);
    check("req_latency", n, 32'd1);
    check("t1_sel", sensor_sel, 32'h0000_0008);
    check("t1_cmd", {24'b0, sensor_request}, 32'h21);
    @(negedge clock);
    check("req_pulse", {31'b0, sensor_req_valid}, 32'h0);
    check("t1_sel_hold", sensor_sel, 32'h0000_0008);
    repeat (8) @(negedge clock);
    tx_busy = 1'b1;
    respond(8'h00, 16'hBEEF);
    #1 check("busy_blocks", {31'b0, tx_valid}, 32'h0);
    check("t1_sel_clr", sensor_sel, 32'h0);
    @(negedge clock);
    check("busy_blocks2", {31'b0, tx_valid}, 32'h0);
    tx_busy = 1'b0;
    recv_byte(8'h00, "t1_b0", n);
    check("t1_unblock", n, 32'd0);
    recv_byte(8'hBE, "t1_b1", n);
    recv_byte(8'hEF, "t1_b2", n);

    // Invalid addresses; a stray response during SEND is ignored
    foreach (bad_addr[i]) begin
      send_frame(bad_addr[i], 8'h01);
      @(negedge clock);
      check("bad_sel", sensor_sel, 32'h0);
      check("bad_req", {31'b0, sensor_req_valid}, 32'h0);
      sensor_rsp_valid = 1'b1;
      sensor_rsp_code  = 8'h77;
      sensor_rsp_data  = 16'hFFFF;
      recv_byte(8'hE0, "bad_b0", n);
      sensor_rsp_valid = 1'b0;
      recv_byte(8'h00, "bad_b1", n);
      recv_byte(8'h00, "bad_b2", n);
    end

    // Timeout at WAIT cycle 100
    send_frame(8'h05, 8'h33);
    wait_req(n);
    repeat (100) @(negedge clock);
    #1 check("tmo_still_wait", {31'b0, tx_valid}, 32'h0);
    check("tmo_sel", sensor_sel, 32'h0000_0020);
    recv_byte(8'hE1, "tmo_b0", n);
    check("tmo_cycle", n, 32'd1);
    recv_byte(8'h00, "tmo_b1", n);
    recv_byte(8'h00, "tmo_b2", n);

    // Response on the expiry cycle wins
    send_frame(8'h05, 8'h34);
    wait_req(n);
    repeat (100) @(negedge clock);
    sensor_rsp_valid = 1'b1;
    sensor_rsp_code  = 8'h5A;
    sensor_rsp_data  = 16'h1234;
    @(negedge clock);
    sensor_rsp_valid = 1'b0;
    recv_byte(8'h5A, "race_b0", n);
    check("rsp_to_tx", n, 32'd0);
    recv_byte(8'h12, "race_b1", n);
    recv_byte(8'h34, "race_b2", n);

    // Six frames while the first is in flight: four queue, the sixth drops
    for (int unsigned k = 1; k <= 6; k++) begin
      if (k == 6) check("ovf_before", {31'b0, fifo_overflow}, 32'h0);
      send_frame(8'(k), 8'(8'h10 + k));
    end
    @(negedge clock);
    check("ovf_after", {31'b0, fifo_overflow}, 32'h1);
    for (int unsigned k = 1; k <= 5; k++) begin
      if (k != 1) wait_req(n);
      check("q_sel", sensor_sel, 32'h1 << k);
      check("q_cmd", {24'b0, sensor_request}, 32'h10 + k);
      respond(8'(k), 16'(16'hA000 + k));
      recv_byte(8'(k), "q_b0", n);
      recv_byte(8'hA0, "q_b1", n);
      recv_byte(8'(k), "q_b2", n);
    end
    cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (sensor_req_valid) cnt++;
    end
    check("q_dropped", cnt, 32'd0);
    check("ovf_sticky", {31'b0, fifo_overflow}, 32'h1);

    // Reset mid-WAIT with a partial frame pending
    send_frame(8'h04, 8'h66);
    wait_req(n);
    send_byte(8'h09);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_quiet("rst_wait");
    reset = 1'b0;
    send_frame(8'h02, 8'h55);
    wait_req(n);
    check("post_rst_lat", n, 32'd1);
    check("post_rst_sel", sensor_sel, 32'h0000_0004);
    check("post_rst_cmd", {24'b0, sensor_request}, 32'h55);

    // Reset mid-SEND while UART holds the first byte
    respond(8'h00, 16'h0102);
    wait_tx(n);
    check("rs_b0", {24'b0, tx_data}, 32'h00);
    @(posedge clock);
    #1 tx_busy = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_quiet("rst_send");
    tx_busy = 1'b0;
    tx_done = 1'b1;
    @(posedge clock);
    #1 tx_done = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (tx_valid) cnt++;
    end
    check("rs_no_tx", cnt, 32'd0);

    // Highest valid address after reset
    send_frame(8'h1F, 8'h44);
    wait_req(n);
    check("top_lat", n, 32'd1);
    check("top_sel", sensor_sel, 32'h8000_0000);
    respond(8'h3C, 16'hCAFE);
    recv_byte(8'h3C, "top_b0", n);
    recv_byte(8'hCA, "top_b1", n);
    recv_byte(8'hFE, "top_b2", n);

`ifdef SENSOR_HUB_CHECKSUM_EN
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h12);
    wait_req(n);
    check("cs_sel", sensor_sel, 32'h0000_0004);
    check("cs_cmd", {24'b0, sensor_request}, 32'h10);
    respond(8'h01, 16'h0203);
    recv_byte(8'h01, "cs_b0", n);
    recv_byte(8'h02, "cs_b1", n);
    recv_byte(8'h03, "cs_b2", n);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h13);
    @(negedge clock);
    check("csbad_req", {31'b0, sensor_req_valid}, 32'h0);
    check("csbad_sel", sensor_sel, 32'h0);
    recv_byte(8'hE2, "csbad_b0", n);
    recv_byte(8'h00, "csbad_b1", n);
    recv_byte(8'h00, "csbad_b2", n);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
